// File: rtl/ata_pio_pkg.sv
// ata_pio_pkg: shared types and helpers for the PIO transfer sequencer.
//   state_t    - sequencer states (IDLE, T1, T2, WAIT, RECOV)
//   tim_set_t  - one timing set {t1, t2, t4, teoc}; every field holds cycles-1
//   PIO_*_DEF  - mode-0 command-port defaults
//   unpack_tim - splits a {Teoc,T4,T2,T1} bus into a tim_set_t
//   max_tw     - larger of two timing fields
package ata_pio_pkg;

    localparam int TW = 8;

    localparam logic [TW-1:0] PIO_T1_DEF   = 8'd6;
    localparam logic [TW-1:0] PIO_T2_DEF   = 8'd28;
    localparam logic [TW-1:0] PIO_T4_DEF   = 8'd2;
    localparam logic [TW-1:0] PIO_TEOC_DEF = 8'd23;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        T1    = 3'd1,
        T2    = 3'd2,
        WAIT  = 3'd3,
        RECOV = 3'd4
    } state_t;

    typedef struct packed {
        logic [TW-1:0] t1;
        logic [TW-1:0] t2;
        logic [TW-1:0] t4;
        logic [TW-1:0] teoc;
    } tim_set_t;

    function automatic tim_set_t unpack_tim(input logic [4*TW-1:0] bus);
        tim_set_t s;
        s.t1   = bus[TW-1:0];
        s.t2   = bus[2*TW-1:TW];
        s.t4   = bus[3*TW-1:2*TW];
        s.teoc = bus[4*TW-1:3*TW];
        return s;
    endfunction

    function automatic logic [TW-1:0] max_tw(input logic [TW-1:0] a, input logic [TW-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ata_pio_timer.sv
// ata_pio_timer: loadable down-counter used to time PIO phases.
//   CLK_I, nReset - clock, async active-low reset
//   clr           - synchronous return to RST_VAL
//   load, d       - load a phase length (cycles-1); load wins over counting
//   en            - count down by one per cycle, holding at zero
//   zero          - counter is zero (current phase is in its last cycle)
module ata_pio_timer #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         CLK_I,
    input  logic         nReset,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK_I or negedge nReset) begin
        if (!nReset) begin
            cnt <= RST_VAL;
        end else if (clr) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= d;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ata_pio_seq.sv
// ata_pio_seq: one ATA PIO register/data cycle per request.
//   Host side : go/we/adr/dev/dat_i request, q read data, done/err pulses,
//               busy, timing sets cmd_tim/dev0_tim/dev1_tim ({Teoc,T4,T2,T1}),
//               fast_en per device, iordy_en {dev1,dev0,cmd}.
//   ATA side  : DDi/DDo/DDoe data bus, DA, CS0n, CS1n, DIORn, DIOWn, IORDY.
//   state_dbg : current sequencer state (state_t encoding).
//
// Handshake: go is sampled only while busy=0. The accepting edge raises busy;
// done (with err on an IORDY timeout) pulses for one cycle in the first
// recovery cycle, and busy falls when the sequencer is back in IDLE. go still
// high when recovery ends starts another transfer.
module ata_pio_seq
    import ata_pio_pkg::*;
#(
    parameter int TWIDTH    = TW,
    parameter int PIO_T1    = 6,
    parameter int PIO_T2    = 28,
    parameter int PIO_T4    = 2,
    parameter int PIO_TEOC  = 23,
    parameter int IORDY_TMO = 125
) (
    input  logic                CLK_I,
    input  logic                nReset,
    input  logic                RST_I,
    input  logic                go,
    input  logic                we,
    input  logic [3:0]          adr,
    input  logic                dev,
    input  logic [15:0]         dat_i,
    input  logic [4*TWIDTH-1:0] cmd_tim,
    input  logic [4*TWIDTH-1:0] dev0_tim,
    input  logic [4*TWIDTH-1:0] dev1_tim,
    input  logic [1:0]          fast_en,
    input  logic [2:0]          iordy_en,
    output logic [15:0]         q,
    output logic                done,
    output logic                err,
    output logic                busy,
    output logic [2:0]          state_dbg,
    input  logic [15:0]         DDi,
    output logic [15:0]         DDo,
    output logic                DDoe,
    output logic [2:0]          DA,
    output logic                CS0n,
    output logic                CS1n,
    output logic                DIORn,
    output logic                DIOWn,
    input  logic                IORDY
);

    localparam int                TMO_W    = $clog2(IORDY_TMO + 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(IORDY_TMO - 1);

    state_t state, state_nx;

    logic iordy_s1, iordy_s;

    tim_set_t          sel_tim;
    logic              sel_ien;
    logic [TWIDTH-1:0] t2_l, t4_l, teoc_l;
    logic              ien_l, we_l;

    logic accept, enter_t2, enter_wait, enter_recov, timeout, leave;

    logic              ph_load, ph_zero, t4_zero;
    logic [TWIDTH-1:0] ph_d;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_zero;

    // Timing set for the request on the bus: fast sets apply only to the
    // data port (adr 0) of a device whose fast timing is enabled.
    always_comb begin
        sel_tim = unpack_tim(cmd_tim);
        sel_ien = iordy_en[0];
        if ((adr == 4'b0000) && fast_en[dev]) begin
            if (dev) begin
                sel_tim = unpack_tim(dev1_tim);
                sel_ien = iordy_en[2];
            end else begin
                sel_tim = unpack_tim(dev0_tim);
                sel_ien = iordy_en[1];
            end
        end
    end

    // IORDY is asynchronous to CLK_I.
    always_ff @(posedge CLK_I or negedge nReset) begin
        if (!nReset) begin
            iordy_s1 <= 1'b0;
            iordy_s  <= 1'b0;
        end else if (RST_I) begin
            iordy_s1 <= 1'b0;
            iordy_s  <= 1'b0;
        end else begin
            iordy_s1 <= IORDY;
            iordy_s  <= iordy_s1;
        end
    end

    always_ff @(posedge CLK_I or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else if (RST_I) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        enter_t2    = 1'b0;
        enter_wait  = 1'b0;
        enter_recov = 1'b0;
        timeout     = 1'b0;
        leave       = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    accept   = 1'b1;
                    state_nx = T1;
                end
            end
            T1: begin
                if (ph_zero) begin
                    enter_t2 = 1'b1;
                    state_nx = T2;
                end
            end
            T2: begin
                if (ph_zero) begin
                    if (ien_l && !iordy_s) begin
                        enter_wait = 1'b1;
                        state_nx   = WAIT;
                    end else begin
                        enter_recov = 1'b1;
                        state_nx    = RECOV;
                    end
                end
            end
            WAIT: begin
                // A ready device wins over a timeout expiring in the same cycle.
                if (iordy_s) begin
                    enter_recov = 1'b1;
                    state_nx    = RECOV;
                end else if (tmo_zero) begin
                    enter_recov = 1'b1;
                    timeout     = 1'b1;
                    state_nx    = RECOV;
                end
            end
            RECOV: begin
                if (ph_zero) begin
                    leave    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // One counter times T1, T2 and the whole recovery (max(T4,Teoc));
    // a second one times only the T4 data hold inside recovery.
    assign ph_load = accept | enter_t2 | enter_recov;

    always_comb begin
        ph_d = sel_tim.t1;
        if (enter_t2) begin
            ph_d = t2_l;
        end else if (enter_recov) begin
            ph_d = max_tw(t4_l, teoc_l);
        end
    end

    ata_pio_timer #(
        .W       (TWIDTH),
        .RST_VAL (TWIDTH'(PIO_T1))
    ) u_phase_timer (
        .CLK_I  (CLK_I),
        .nReset (nReset),
        .clr    (RST_I),
        .load   (ph_load),
        .en     (state != IDLE),
        .d      (ph_d),
        .zero   (ph_zero)
    );

    ata_pio_timer #(
        .W       (TWIDTH),
        .RST_VAL ('0)
    ) u_t4_timer (
        .CLK_I  (CLK_I),
        .nReset (nReset),
        .clr    (RST_I),
        .load   (enter_recov),
        .en     (state == RECOV),
        .d      (t4_l),
        .zero   (t4_zero)
    );

    always_ff @(posedge CLK_I or negedge nReset) begin
        if (!nReset) begin
            tmo_cnt <= '0;
        end else if (RST_I) begin
            tmo_cnt <= '0;
        end else if (enter_wait) begin
            tmo_cnt <= TMO_LOAD;
        end else if ((state == WAIT) && !tmo_zero) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign tmo_zero = (tmo_cnt == '0);

    // Latched request and all registered ATA pins. The latched timing set
    // idles at the command-port defaults.
    always_ff @(posedge CLK_I or negedge nReset) begin
        if (!nReset) begin
            we_l   <= 1'b0;
            ien_l  <= 1'b0;
            t2_l   <= TWIDTH'(PIO_T2);
            t4_l   <= TWIDTH'(PIO_T4);
            teoc_l <= TWIDTH'(PIO_TEOC);
            q      <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            DDo    <= '0;
            DDoe   <= 1'b0;
            DA     <= '0;
            CS0n   <= 1'b1;
            CS1n   <= 1'b1;
            DIORn  <= 1'b1;
            DIOWn  <= 1'b1;
        end else if (RST_I) begin
            we_l   <= 1'b0;
            ien_l  <= 1'b0;
            t2_l   <= TWIDTH'(PIO_T2);
            t4_l   <= TWIDTH'(PIO_T4);
            teoc_l <= TWIDTH'(PIO_TEOC);
            q      <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            DDo    <= '0;
            DDoe   <= 1'b0;
            DA     <= '0;
            CS0n   <= 1'b1;
            CS1n   <= 1'b1;
            DIORn  <= 1'b1;
            DIOWn  <= 1'b1;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (accept) begin
                we_l   <= we;
                ien_l  <= sel_ien;
                t2_l   <= sel_tim.t2;
                t4_l   <= sel_tim.t4;
                teoc_l <= sel_tim.teoc;
                CS0n   <= adr[3];
                CS1n   <= ~adr[3];
                DA     <= adr[2:0];
                if (we) begin
                    DDo  <= dat_i;
                    DDoe <= 1'b1;
                end
            end
            if (enter_t2) begin
                if (we_l) begin
                    DIOWn <= 1'b0;
                end else begin
                    DIORn <= 1'b0;
                end
            end
            if (enter_recov) begin
                DIORn <= 1'b1;
                DIOWn <= 1'b1;
                done  <= 1'b1;
                err   <= timeout;
                if (!we_l) begin
                    q <= DDi;
                end
            end
            if ((state == RECOV) && t4_zero) begin
                DDoe <= 1'b0;
            end
            if (leave) begin
                CS0n <= 1'b1;
                CS1n <= 1'b1;
                DA   <= '0;
                DDoe <= 1'b0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
